// File: rtl/dspl_pkg.sv
// ---------------------------------------------------------------------------
// dspl_pkg
// Shared definitions for the 8-digit display slice.
//   DIGIT_W      bits per digit image {en, hex[3:0], dp}
//   N_DIGITS     digits on the display
//   DISP_W       width of a whole packed display image (d1 in the LSBs)
//   DIGIT_BLANK  image of one dark digit
//   DISP_BLANK   image of a fully dark display
//   arb_state_t  ownership states of the display share arbiter
// ---------------------------------------------------------------------------
package dspl_pkg;

    localparam int DIGIT_W  = 6;
    localparam int N_DIGITS = 8;
    localparam int DISP_W   = DIGIT_W * N_DIGITS;

    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 6'b0;
    localparam logic [DISP_W-1:0]  DISP_BLANK  = {N_DIGITS{DIGIT_BLANK}};

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BLANK
    } arb_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen
// Free-running millisecond strobe. Emits a one-clock pulse every
// 2*HALF_MS_COUNT clocks. The phase restarts from zero on reset, so the
// first pulse comes 2*HALF_MS_COUNT clocks after reset is released.
// Other timers (debounce, blink) can share this block.
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   tick_o  out  one-cycle millisecond strobe
// ---------------------------------------------------------------------------
module ms_tick_gen #(
    parameter int HALF_MS_COUNT = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int PERIOD = 2 * HALF_MS_COUNT;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts 0 .. PERIOD-1 and wraps; the strobe is raised on the last count
    // so every strobe is exactly PERIOD clocks after the previous one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = (r_cnt == LAST);

endmodule

// File: rtl/dspl_share_arb.sv
// ---------------------------------------------------------------------------
// dspl_share_arb
// Time-shares the 8-digit display driver between N_REQ requesters. Owners
// are chosen round-robin, keep the display for at least HOLD_MS while others
// wait, and hand over through an optional BLANK_MS dark gap.
// Ports:
//   clk_i     in   system clock
//   rst_i     in   synchronous active-high reset
//   req_i     in   per-requester level request
//   digits_i  in   requester k image at [48k+47:48k]
//   gnt_o     out  one-hot grant, zero when idle or blanking
//   owner_o   out  index of the current / last owner
//   digits_o  out  packed d1..d8 image for the display driver
//   busy_o    out  high while granting or blanking
// ---------------------------------------------------------------------------
module dspl_share_arb
    import dspl_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int HALF_MS_COUNT = 50000,
    parameter int HOLD_MS       = 500,
    parameter int BLANK_MS      = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DISP_W-1:0]    digits_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic [DISP_W-1:0]          digits_o,
    output logic                       busy_o
);

    localparam int OW     = $clog2(N_REQ);
    localparam int MS_MAX = (HOLD_MS > BLANK_MS) ? HOLD_MS : BLANK_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] HOLD_VAL   = MS_W'(HOLD_MS);
    localparam logic [MS_W-1:0] BLANK_LAST = MS_W'((BLANK_MS > 0) ? BLANK_MS - 1 : 0);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     w_nextOwner;
    logic [OW-1:0]     r_rrPtr;
    logic [OW-1:0]     w_nextRr;
    logic [MS_W-1:0]   r_msCnt;
    logic [MS_W-1:0]   w_nextMs;
    logic [DISP_W-1:0] r_digits;
    logic [DISP_W-1:0] w_images [N_REQ];
    logic [N_REQ-1:0]  w_ownerOneHot;
    logic [OW:0]       w_pick;
    logic              w_ownerReq;
    logic              w_othersReq;
    logic              w_release;
    logic              w_tick;

    // Round-robin search starting just after ptr and wrapping. The last
    // granted index sits at ptr, so it is visited last and only wins when
    // nobody else is asking. Returns {found, index}.
    function automatic logic [OW:0] rrPick(input logic [N_REQ-1:0] req,
                                           input logic [OW-1:0]    ptr);
        logic [OW:0]   result;
        logic [OW-1:0] candIdx;
        result = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            candIdx = OW'((int'(ptr) + i) % N_REQ);
            if (req[candIdx]) begin
                result = {1'b1, candIdx};
            end
        end
        return result;
    endfunction

    ms_tick_gen #(
        .HALF_MS_COUNT(HALF_MS_COUNT)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (w_tick)
    );

    // Unpack the requester images so the owner's image is a plain array read.
    for (genvar k = 0; k < N_REQ; k++) begin : g_images
        assign w_images[k] = digits_i[k*DISP_W +: DISP_W];
    end

    assign w_ownerOneHot = N_REQ'(1) << r_owner;
    assign w_ownerReq    = req_i[r_owner];
    assign w_othersReq   = |(req_i & ~w_ownerOneHot);
    assign w_pick        = rrPick(req_i, r_rrPtr);

    // An owner lets go as soon as it stops asking; otherwise only once the
    // hold time has fully elapsed and someone else is actually waiting.
    assign w_release = !w_ownerReq || ((r_msCnt == HOLD_VAL) && w_othersReq);

    // Next-state logic. The ms counter doubles as hold timer in GRANT and
    // gap timer in BLANK, and is zeroed on every ownership change so each
    // phase starts counting fresh.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextRr    = r_rrPtr;
        w_nextMs    = r_msCnt;
        case (r_state)
            IDLE: begin
                w_nextMs = '0;
                if (w_pick[OW]) begin
                    w_nextState = GRANT;
                    w_nextOwner = w_pick[OW-1:0];
                    w_nextRr    = w_pick[OW-1:0];
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_nextMs = '0;
                    if (BLANK_MS > 0) begin
                        w_nextState = BLANK;
                    end else if (w_pick[OW]) begin
                        w_nextOwner = w_pick[OW-1:0];
                        w_nextRr    = w_pick[OW-1:0];
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (w_tick && (r_msCnt != HOLD_VAL)) begin
                    w_nextMs = r_msCnt + 1'b1;
                end
            end
            BLANK: begin
                if (w_tick) begin
                    if (r_msCnt == BLANK_LAST) begin
                        w_nextMs = '0;
                        if (w_pick[OW]) begin
                            w_nextState = GRANT;
                            w_nextOwner = w_pick[OW-1:0];
                            w_nextRr    = w_pick[OW-1:0];
                        end else begin
                            w_nextState = IDLE;
                        end
                    end else begin
                        w_nextMs = r_msCnt + 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextMs    = '0;
            end
        endcase
    end

    // State and output registers. The image lags the grant by one clock and
    // is only passed through while a grant continues into the next cycle, so
    // the display goes dark on the same edge the grant is withdrawn and a
    // direct owner switch never shows a dark frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rrPtr  <= OW'(N_REQ - 1);
            r_msCnt  <= '0;
            r_digits <= DISP_BLANK;
        end else begin
            r_state  <= w_nextState;
            r_owner  <= w_nextOwner;
            r_rrPtr  <= w_nextRr;
            r_msCnt  <= w_nextMs;
            if ((r_state == GRANT) && (w_nextState == GRANT)) begin
                r_digits <= w_images[r_owner];
            end else begin
                r_digits <= DISP_BLANK;
            end
        end
    end

    assign gnt_o    = (r_state == GRANT) ? w_ownerOneHot : '0;
    assign owner_o  = r_owner;
    assign digits_o = r_digits;
    assign busy_o   = (r_state != IDLE);

    // The display may have at most one owner at any time.
    a_gntOneHot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));

endmodule

// File: tb/tb_dspl_share_arb.sv
// ---------------------------------------------------------------------------
// tb_dspl_share_arb
// Drives two arbiters from the same stimulus: one with a 1 ms blank gap and
// one that switches owners directly. Both are compared every cycle against
// an ownership model kept here, and hand-worked scenarios pin the model.
// ---------------------------------------------------------------------------
module tb_dspl_share_arb;

    localparam int N       = 4;
    localparam int HALF_MS = 2;
    localparam int HOLD    = 3;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [191:0] digits;

    logic [3:0]   gntA;
    logic [1:0]   ownerA;
    logic [47:0]  digitsA;
    logic         busyA;
    logic [3:0]   gntB;
    logic [1:0]   ownerB;
    logic [47:0]  digitsB;
    logic         busyB;

    int testCount = 0;
    int failCount = 0;

    // Model state per instance: index 0 has a 1 ms gap, index 1 has none.
    int          mOwner    [2];
    bit          mBlank    [2];
    int          mMs       [2];
    int          mLast     [2];
    int          mOwnerOut [2];
    logic [47:0] mDigits   [2];
    int          mPhase;
    bit          mValid = 1'b0;

    int order [$];

    dspl_share_arb #(
        .N_REQ(N), .HALF_MS_COUNT(HALF_MS), .HOLD_MS(HOLD), .BLANK_MS(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .digits_i(digits),
        .gnt_o(gntA), .owner_o(ownerA), .digits_o(digitsA), .busy_o(busyA)
    );

    dspl_share_arb #(
        .N_REQ(N), .HALF_MS_COUNT(HALF_MS), .HOLD_MS(HOLD), .BLANK_MS(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .digits_i(digits),
        .gnt_o(gntB), .owner_o(ownerB), .digits_o(digitsB), .busy_o(busyB)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Wait until just after the next falling edge, where inputs are changed.
    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    // Set reset and requests, then let the given number of clocks elapse.
    task automatic applyStimulus(input logic r, input logic [3:0] q, input int cycles);
        rst = r;
        req = q;
        for (int i = 0; i < cycles; i++) begin
            stepCycle();
        end
    endtask

    function automatic int blankMsOf(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    // First requester after 'last' going round the ring; -1 if none asks.
    function automatic int pickNext(input logic [3:0] q, input int last);
        int c;
        for (int s = 1; s <= N; s++) begin
            c = (last + s) % N;
            if (q[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [47:0] imageOf(input int k);
        logic [191:0] all;
        all = digits;
        return all[k*48 +: 48];
    endfunction

    // One clock of the ownership rules, evaluated with the inputs present at
    // the rising edge.
    task automatic modelStep();
        bit tick;
        int prev;
        int p;
        bit others;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mOwner[k] = -1; mBlank[k] = 1'b0; mMs[k] = 0;
                mLast[k] = N - 1; mOwnerOut[k] = 0; mDigits[k] = '0;
            end
            mPhase = 0;
            mValid = 1'b1;
        end else begin
            tick   = (mPhase == 2 * HALF_MS - 1);
            mPhase = (mPhase + 1) % (2 * HALF_MS);
            for (int k = 0; k < 2; k++) begin
                prev = mOwner[k];
                p    = pickNext(req, mLast[k]);
                if (prev >= 0) begin
                    others = (req & ~(4'b0001 << prev)) != 4'b0000;
                    if (!req[prev] || (mMs[k] == HOLD && others)) begin
                        mMs[k] = 0;
                        if (blankMsOf(k) > 0) begin
                            mOwner[k] = -1;
                            mBlank[k] = 1'b1;
                        end else begin
                            mOwner[k] = p;
                        end
                    end else if (tick && mMs[k] < HOLD) begin
                        mMs[k]++;
                    end
                end else if (mBlank[k]) begin
                    if (tick) begin
                        mMs[k]++;
                        if (mMs[k] >= blankMsOf(k)) begin
                            mMs[k]    = 0;
                            mBlank[k] = 1'b0;
                            mOwner[k] = p;
                        end
                    end
                end else begin
                    mMs[k]    = 0;
                    mOwner[k] = p;
                end
                if (mOwner[k] >= 0 && mOwner[k] != prev) begin
                    mLast[k]     = mOwner[k];
                    mOwnerOut[k] = mOwner[k];
                end
                mDigits[k] = (prev >= 0 && mOwner[k] >= 0) ? imageOf(prev) : 48'h0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every falling edge, both instances must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mValid) begin
                checkOutput("A gnt",    gntA,    (mOwner[0] >= 0) ? (64'd1 << mOwner[0]) : 64'd0);
                checkOutput("A owner",  ownerA,  mOwnerOut[0]);
                checkOutput("A digits", digitsA, mDigits[0]);
                checkOutput("A busy",   busyA,   (mOwner[0] >= 0) || mBlank[0]);
                checkOutput("B gnt",    gntB,    (mOwner[1] >= 0) ? (64'd1 << mOwner[1]) : 64'd0);
                checkOutput("B owner",  ownerB,  mOwnerOut[1]);
                checkOutput("B digits", digitsB, mDigits[1]);
                checkOutput("B busy",   busyB,   (mOwner[1] >= 0) || mBlank[1]);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        digits = '0;

        // Reset values
        applyStimulus(1'b1, 4'b0000, 2);
        checkOutput("reset gnt",    gntA,    4'b0000);
        checkOutput("reset owner",  ownerA,  2'd0);
        checkOutput("reset digits", digitsA, 48'h0);
        checkOutput("reset busy",   busyA,   1'b0);

        // Single request: grant after one clock, image one clock later
        digits[95:48] = 48'h0A5;
        applyStimulus(1'b0, 4'b0010, 1);
        checkOutput("t1 gnt",   gntA,   4'b0010);
        checkOutput("t1 owner", ownerA, 2'd1);
        checkOutput("t1 busy",  busyA,  1'b1);
        stepCycle();
        checkOutput("t1 digits", digitsA, 48'h0A5);

        // Hold for 3 ticks while 3 waits, then one blank tick, then 3
        applyStimulus(1'b0, 4'b1010, 10);
        checkOutput("t2 held gnt", gntA, 4'b0010);
        stepCycle();
        checkOutput("t2 blank gnt",    gntA,    4'b0000);
        checkOutput("t2 blank busy",   busyA,   1'b1);
        checkOutput("t2 blank digits", digitsA, 48'h0);
        checkOutput("t2 direct gnt",   gntB,    4'b1000);
        applyStimulus(1'b0, 4'b1010, 3);
        checkOutput("t2 next gnt",   gntA,   4'b1000);
        checkOutput("t2 next owner", ownerA, 2'd3);

        // Reset mid-grant, then restart with 0 and 3 requesting
        applyStimulus(1'b0, 4'b1010, 2);
        applyStimulus(1'b1, 4'b1010, 1);
        checkOutput("t5 gnt",    gntA,    4'b0000);
        checkOutput("t5 owner",  ownerA,  2'd0);
        checkOutput("t5 digits", digitsA, 48'h0);
        checkOutput("t5 busy",   busyA,   1'b0);
        digits[47:0]    = 48'h3F2A150C3321;
        digits[191:144] = 48'hABCDEF012345;
        applyStimulus(1'b0, 4'b1001, 1);
        checkOutput("t5 restart gnt",   gntA,   4'b0001);
        checkOutput("t5 restart owner", ownerA, 2'd0);

        // Direct switch at hold expiry never shows a dark frame
        applyStimulus(1'b0, 4'b1001, 11);
        checkOutput("t6 held gnt", gntB, 4'b0001);
        stepCycle();
        checkOutput("t6 switch gnt",    gntB,    4'b1000);
        checkOutput("t6 switch digits", digitsB, 48'h3F2A150C3321);
        checkOutput("t6 gap gnt",       gntA,    4'b0000);
        stepCycle();
        checkOutput("t6 new digits", digitsB, 48'hABCDEF012345);

        // Everyone requesting: grants rotate 0,1,2,3,0
        applyStimulus(1'b1, 4'b1111, 1);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            stepCycle();
            if (gntA != 4'b0000 && (order.size() == 0 || order[$] != int'(ownerA)))
                order.push_back(int'(ownerA));
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3 order[%0d]", i),
                        (i < order.size()) ? order[i] : -1, i % 4);
        end

        // Owner drops early: release at once; sole requester keeps the grant
        applyStimulus(1'b1, 4'b0001, 1);
        applyStimulus(1'b0, 4'b0001, 6);
        applyStimulus(1'b0, 4'b0100, 1);
        checkOutput("t4 drop gnt",  gntA,  4'b0000);
        checkOutput("t4 drop busy", busyA, 1'b1);
        applyStimulus(1'b0, 4'b0100, 60);
        checkOutput("t4 keep gnt",   gntA,   4'b0100);
        checkOutput("t4 keep owner", ownerA, 2'd2);

        // Random traffic with live image updates and occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int w = 0; w < 6; w++) digits[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 299) == 0);
            stepCycle();
        end

        rst = 1'b0;
        stepCycle();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
